// File: rtl/glay_cu_read_request_generator_pkg.sv
// Shared types and constants for the compute-unit cache read request generator.
package glay_cu_read_request_generator_pkg;

    localparam int CACHE_FRONTEND_ADDR_W     = 64;
    localparam int CACHE_FRONTEND_DATA_W     = 512;
    localparam int READ_GEN_CNT_W            = 32;
    // One request per cache line, so the stride follows the data width.
    localparam int READ_GEN_STRIDE_LOG2      = $clog2(CACHE_FRONTEND_DATA_W / 8);
    localparam int READ_GEN_MAX_OUTSTANDING  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } ReadGenState;

    typedef struct packed {
        logic [CACHE_FRONTEND_ADDR_W-1:0] base_addr;
        logic [READ_GEN_CNT_W-1:0]        num_req;
    } GlayReadGenConfig;

endpackage

// File: rtl/glay_cu_read_request_generator_if.sv
// Request/response FIFO bundle between the read generator and the cache frontend FIFOs.
interface glay_cu_read_request_generator_if
    import glay_cu_read_request_generator_pkg::*;
#(
    parameter int ADDR_W = CACHE_FRONTEND_ADDR_W,
    parameter int DATA_W = CACHE_FRONTEND_DATA_W
);
    logic                  req_valid;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  req_ready;
    logic                  rsp_empty;
    logic                  rsp_rd_en;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, rsp_rd_en,
        input  req_ready, rsp_empty, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, rsp_rd_en,
        output req_ready, rsp_empty, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/glay_outstanding_counter.sv
// Up/down counter of in-flight requests with limit and zero flags.
// A simultaneous increment and decrement leaves the count unchanged.
module glay_outstanding_counter #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_at_limit,
    output logic o_is_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + W'(1);
        end else if (!i_inc && i_dec) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_at_limit = (r_count >= W'(LIMIT));
    assign o_is_zero  = (r_count == '0);

endmodule

// File: rtl/glay_cu_read_request_generator.sv
// Walks a contiguous line array, issuing one cache read per cycle under backpressure and an
// outstanding cap, forwards the responses and pulses done when every request is answered.
module glay_cu_read_request_generator
    import glay_cu_read_request_generator_pkg::*;
#(
    parameter int ADDR_W          = CACHE_FRONTEND_ADDR_W,
    parameter int DATA_W          = CACHE_FRONTEND_DATA_W,
    parameter int CNT_W           = READ_GEN_CNT_W,
    parameter int STRIDE_LOG2     = READ_GEN_STRIDE_LOG2,
    parameter int MAX_OUTSTANDING = READ_GEN_MAX_OUTSTANDING
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_req,
    output logic              busy,
    output logic              done,
    output logic              rsp_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  rsp_count,
    glay_cu_read_request_generator_if.master cache
);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << STRIDE_LOG2) - 1);

    ReadGenState       r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_num_req;
    logic [CNT_W-1:0]  r_issue_idx;
    logic [CNT_W-1:0]  r_rsp_count;
    logic              r_busy;
    logic              r_done;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_rd_inflight;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_rsp_err;

    logic              w_start_job;
    logic              w_issue;
    logic [CNT_W-1:0]  w_idx_next;
    logic              w_at_limit;
    logic              w_none_outstanding;
    logic              w_rsp_accept;
    logic              w_rd_en;

    assign w_start_job  = (r_state == IDLE) && start && (num_req != '0);
    assign w_issue      = (r_state == ISSUE) && cache.req_ready && !w_at_limit;
    assign w_idx_next   = r_issue_idx + CNT_W'(1);
    assign w_rsp_accept = cache.rsp_valid && !w_none_outstanding;
    // Only one pop may be in flight across the FIFO's one-cycle read latency.
    assign w_rd_en      = ap_rst_n && !cache.rsp_empty && !r_rd_inflight;

    glay_outstanding_counter #(
        .LIMIT (MAX_OUTSTANDING)
    ) u_outstanding (
        .i_clk      (ap_clk),
        .i_rst_n    (ap_rst_n),
        .i_clr      (w_start_job),
        .i_inc      (w_issue),
        .i_dec      (w_rsp_accept),
        .o_at_limit (w_at_limit),
        .o_is_zero  (w_none_outstanding)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_num_req   <= '0;
            r_issue_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            r_req_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (num_req != '0) begin
                            r_base      <= base_addr & LINE_MASK;
                            r_num_req   <= num_req;
                            r_issue_idx <= '0;
                            r_state     <= ISSUE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_base + (ADDR_W'(r_issue_idx) << STRIDE_LOG2);
                        r_issue_idx <= w_idx_next;
                        if (w_idx_next == r_num_req) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_rsp_count == r_num_req) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // done and the busy drop land together in the cycle after DONE.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_inflight <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_rsp_count   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_rd_inflight <= w_rd_en;
            r_out_valid   <= w_rsp_accept;
            if (w_rsp_accept) begin
                r_out_data <= cache.rsp_rdata;
            end
            // A response with nothing outstanding is dropped and flagged until reset.
            if (cache.rsp_valid && w_none_outstanding) begin
                r_rsp_err <= 1'b1;
            end
            if (w_start_job) begin
                r_rsp_count <= '0;
            end else if (w_rsp_accept) begin
                r_rsp_count <= r_rsp_count + CNT_W'(1);
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign rsp_err         = r_rsp_err;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign rsp_count       = r_rsp_count;
    assign cache.req_valid = r_req_valid;
    assign cache.req_addr  = r_req_addr;
    assign cache.req_wdata = '0;
    assign cache.req_wstrb = '0;
    assign cache.rsp_rd_en = w_rd_en;

endmodule

// File: tb/tb_glay_cu_read_request_generator.sv
// Directed and randomized jobs against a line-walk reference and an in-order response FIFO model.
module tb_glay_cu_read_request_generator;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_req;
    logic              busy, done, rsp_err, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  rsp_count;

    glay_cu_read_request_generator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    glay_cu_read_request_generator dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_req   (num_req),
        .busy      (busy),
        .done      (done),
        .rsp_err   (rsp_err),
        .out_valid (out_valid),
        .out_data  (out_data),
        .rsp_count (rsp_count),
        .cache     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Controls owned by the main sequence, read by the FIFO model.
    bit          auto_rsp = 1'b1;
    int          release_total = 0;
    int          flush_req = 0;
    int          stray_req = 0;
    logic [31:0] salt = 32'h0;

    // State owned by the FIFO model.
    logic [DATA_W-1:0] rsp_q[$];
    logic [DATA_W-1:0] held[$];
    int                released_cnt = 0;
    int                flush_seen = 0;
    int                stray_seen = 0;
    logic              pop_pend;

    // Observations gathered by the main sequence.
    logic [ADDR_W-1:0] obs_addr[$];
    int                obs_cyc[$];
    logic [DATA_W-1:0] obs_data[$];
    int cyc = 0, done_cnt = 0, stall_viol = 0, issued_tot = 0, answered_tot = 0, max_out = 0;

    function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a, input logic [31:0] s);
        return {8{a ^ {s, ~s}}};
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base, input int i);
        return (base & ~64'h3F) + (64'(i) << 6);
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(k >= 2 && k <= 5);
        return 1'b1;
    endfunction

    initial begin : pop_sampler
        pop_pend = 1'b0;
        forever begin
            @(negedge clk);
            pop_pend = bus.rsp_rd_en;
        end
    end

    initial begin : rsp_fifo_model
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_empty = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (flush_seen != flush_req) begin
                rsp_q.delete();
                held.delete();
                flush_seen   = flush_req;
                released_cnt = release_total;
            end
            while (stray_seen < stray_req) begin
                rsp_q.push_back(mk_data(64'hDEAD_BEEF, salt));
                stray_seen++;
            end
            if (bus.req_valid === 1'b1) held.push_back(mk_data(bus.req_addr, salt));
            while (held.size() > 0 && (auto_rsp || released_cnt < release_total)) begin
                rsp_q.push_back(held.pop_front());
                if (!auto_rsp) released_cnt++;
            end
            bus.rsp_valid = 1'b0;
            if (pop_pend && rsp_q.size() > 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rsp_q.pop_front();
            end
            bus.rsp_empty = (rsp_q.size() == 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic rdy;
        rdy = bus.req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.req_valid === 1'b1) begin
            obs_addr.push_back(bus.req_addr);
            obs_cyc.push_back(cyc);
            issued_tot++;
            if (rdy !== 1'b1) stall_viol++;
        end
        if (out_valid === 1'b1) begin
            obs_data.push_back(out_data);
            answered_tot++;
        end
        if (done === 1'b1) done_cnt++;
        if (issued_tot - answered_tot > max_out) max_out = issued_tot - answered_tot;
    endtask

    task automatic clear_job_stats();
        stall_viol = 0; issued_tot = 0; answered_tot = 0; max_out = 0;
    endtask

    task automatic check_job(input string tag, input logic [ADDR_W-1:0] base, input int n,
                             input int a0, input int d0, input int dn0, input bit timing);
        chk({tag, "_issued"}, obs_addr.size() - a0, n);
        for (int i = 0; i < n && a0 + i < obs_addr.size(); i++) begin
            chk({tag, "_addr"}, obs_addr[a0 + i], line_addr(base, i));
            if (timing) chk({tag, "_addr_cycle"}, obs_cyc[a0 + i] - obs_cyc[a0], i);
        end
        chk({tag, "_responses"}, obs_data.size() - d0, n);
        for (int i = 0; i < n && d0 + i < obs_data.size(); i++)
            chk({tag, "_data"}, obs_data[d0 + i], mk_data(line_addr(base, i), salt));
        chk({tag, "_rsp_count"}, rsp_count, n);
        chk({tag, "_done_pulses"}, done_cnt - dn0, 1);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_stall_issue"}, stall_viol, 0);
        chk({tag, "_cap_kept"}, (max_out <= 16), 1);
    endtask

    task automatic run_job(input string tag, input logic [ADDR_W-1:0] base, input int n,
                           input int mode, input int inj_k);
        int a0, d0, dn0;
        bit got, busy_at_done;
        a0 = obs_addr.size(); d0 = obs_data.size(); dn0 = done_cnt;
        clear_job_stats();
        salt = $urandom; auto_rsp = 1'b1;
        start = 1'b1; base_addr = base; num_req = n;
        bus.req_ready = ready_for(mode, 0);
        got = 1'b0; busy_at_done = 1'b1;
        for (int k = 1; k <= 6 * n + 60 && !got; k++) begin
            step();
            if (done === 1'b1) begin got = 1'b1; busy_at_done = busy; end
            start = (k == inj_k);
            if (k == inj_k) begin
                base_addr = {$urandom, $urandom};
                num_req   = $urandom_range(1, 9);
            end
            bus.req_ready = ready_for(mode, k);
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        step();
        chk({tag, "_done_one_cycle"}, done, 0);
        check_job(tag, base, n, a0, d0, dn0, (mode == 0));
    endtask

    initial begin : main
        logic [ADDR_W-1:0] b;
        int a0, d0, dn0;
        bit got;
        logic [CNT_W-1:0] rc;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_req = '0; bus.req_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_req_addr", bus.req_addr, 0);
        chk("rst_rsp_rd_en", bus.rsp_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rsp_count", rsp_count, 0);
        chk("req_wdata_zero", bus.req_wdata, 0);
        chk("req_wstrb_zero", bus.req_wstrb, 0);
        rst_n = 1'b1;
        bus.req_ready = 1'b1;
        step();

        run_job("basic", 64'h1000, 4, 0, 0);
        run_job("backpressure", 64'h1000, 4, 2, 0);

        // Outstanding cap with withheld responses.
        b = {$urandom, $urandom};
        a0 = obs_addr.size(); d0 = obs_data.size(); dn0 = done_cnt;
        clear_job_stats();
        salt = $urandom; auto_rsp = 1'b0;
        start = 1'b1; base_addr = b; num_req = 40; bus.req_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin step(); start = 1'b0; end
        chk("cap_issued_16", obs_addr.size() - a0, 16);
        chk("cap_no_out", obs_data.size() - d0, 0);
        chk("cap_busy", busy, 1);
        release_total++;
        repeat (12) step();
        chk("cap_issued_17", obs_addr.size() - a0, 17);
        chk("cap_one_out", obs_data.size() - d0, 1);
        auto_rsp = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (done === 1'b1) got = 1'b1;
        end
        chk("cap_done_seen", got, 1);
        chk("cap_max_outstanding", max_out, 16);
        check_job("cap", b, 40, a0, d0, dn0, 1'b0);

        // Zero-length job.
        a0 = obs_addr.size();
        start = 1'b1; num_req = 0; base_addr = 64'h4000;
        step();
        start = 1'b0;
        chk("zero_done_early", done, 0);
        chk("zero_busy", busy, 1);
        step();
        chk("zero_done", done, 1);
        chk("zero_busy_low", busy, 0);
        step();
        chk("zero_no_req", obs_addr.size() - a0, 0);

        run_job("wrap", 64'hFFFF_FFFF_FFFF_FFC0, 2, 0, 0);
        run_job("unaligned", 64'h1007, 3, 0, 0);
        run_job("ignored_start", 64'h2000, 8, 2, 3);
        for (int j = 0; j < 3; j++)
            run_job("random", {$urandom, $urandom}, $urandom_range(1, 24), 1, 0);

        // Stray response while idle.
        chk("stray_err_before", rsp_err, 0);
        d0 = obs_data.size(); rc = rsp_count;
        stray_req++;
        repeat (6) step();
        chk("stray_err", rsp_err, 1);
        chk("stray_no_out", obs_data.size() - d0, 0);
        chk("stray_count_kept", rsp_count, rc);

        // Asynchronous reset in the middle of a job.
        start = 1'b1; base_addr = 64'h8000; num_req = 30; bus.req_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        #3;
        rst_n = 1'b0;
        flush_req++;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_rsp_err", rsp_err, 0);
        chk("arst_req_valid", bus.req_valid, 0);
        chk("arst_req_addr", bus.req_addr, 0);
        chk("arst_rsp_rd_en", bus.rsp_rd_en, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_rsp_count", rsp_count, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        run_job("after_reset", 64'h0003_0000, 5, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
